matmul_tile_scheduler: RTL and testbench
========================================

// Module: matmul_tile_scheduler
// PURPOSE
//  Sequences the 8x8 systolic matmul (four 4x4 tiles) over a large problem C[M,N] = A[M,K] * B[K,N].
//  Matrix dimensions are given in units of 8x8 tiles.
//  For every tile triple (i,j,k) it programs the tile base addresses, raises start_mat_mul and
//  waits for done_mat_mul. It then flags whether the C writeback must accumulate onto prior partials.
//  Sits between the host config registers and matmul_8x8_systolic.
// PARAMETERS
//  AWIDTH      11   address width (matches `AWIDTH)
//  SWIDTH       8   stride width (matches `ADDR_STRIDE_WIDTH)
//  MASK_WIDTH   4   validity mask width (matches `MASK_WIDTH)
//  TWIDTH       4   tile-count width; 1..15 tiles per dimension
//  TIMEOUT    255   max cycles in ISSUE waiting for done_mat_mul before error
// PORTS
//  clk              in   1       clock
//  reset            in   1       asynchronous, active-low reset
//  cfg_start        in   1       1-cycle pulse; latches all cfg_* inputs when idle
//  cfg_base_a/b/c   in   AWIDTH  base addresses of A, B, C
//  cfg_stride_a/b/c in   SWIDTH  per-row strides, passed through to datapath
//  cfg_a_row_step   in   AWIDTH  A addr increment per tile row i
//  cfg_a_col_step   in   AWIDTH  A addr increment per tile k
//  cfg_b_row_step   in   AWIDTH  B addr increment per tile k
//  cfg_b_col_step   in   AWIDTH  B addr increment per tile col j
//  cfg_c_row_step   in   AWIDTH  C addr increment per tile row i
//  cfg_c_col_step   in   AWIDTH  C addr increment per tile col j
//  cfg_m/n/k_tiles  in   TWIDTH  tile counts in M, N, K
//  stall            in   1       downstream C writer busy; blocks issue of next tile
//  start_mat_mul    out  1       level start to datapath
//  done_mat_mul     in   1       datapath done
//  address_mat_a/b/c out AWIDTH  tile base addresses
//  address_stride_a/b/c out SWIDTH latched strides
//  validity_mask_*  out  MASK_WIDTH all-ones while busy, 0 when idle
//  accumulate       out  1       1 when current tile k != 0
//  last_k           out  1       1 when current tile k == k_tiles-1
//  busy / done / err out 1       run active / 1-cycle completion pulse / sticky error
// BEHAVIOUR
//  Reset: state IDLE.
//   - All outputs 0; err cleared; counters i=j=k=0; address outputs = 0.
//   - Async assert; synchronous deassert is the integrator's job.
//  FSM: IDLE -> CHECK -> ISSUE -> RELEASE -> ADVANCE -> (ISSUE | FIN) -> IDLE.
//  IDLE:
//   - cfg_start latches config and clears err.
//   - cfg_start while busy is ignored.
//  CHECK, one cycle:
//   - If any tile count is 0 -> FIN with err=1 and no datapath activity.
//   - Otherwise -> ISSUE.
//  ISSUE:
//   - Addresses are registered and stable for the whole tile:
//     - a = base_a + i*a_row_step + k*a_col_step
//     - b = base_b + k*b_row_step + j*b_col_step
//     - c = base_c + i*c_row_step + j*c_col_step
//   - Arithmetic is modulo 2^AWIDTH (wrap, no error).
//   - If stall=1 on ISSUE entry, start_mat_mul stays 0 until stall=0.
//   - start_mat_mul=1 until done_mat_mul=1 is sampled.
//  RELEASE:
//   - start_mat_mul=0.
//   - Wait until done_mat_mul=0, then go to ADVANCE.
//  ADVANCE, one cycle: k++; on k wrap j++; on j wrap i++; on i wrap go to FIN.
//  Loop order is k innermost, then j, then i.
//  FIN: done=1 for exactly 1 cycle; busy drops the same cycle; -> IDLE.
//  Timeout:
//   - Cycle counter starts when start_mat_mul rises.
//   - It reaches TIMEOUT with no done -> err=1, start_mat_mul=0, -> FIN.
//  Latencies:
//   - cfg_start to first start_mat_mul is 3 cycles with no stall.
//   - Each tile adds issue + datapath + 2 cycles.
//  Counters are TWIDTH bits; a count of 15 must not overflow; compare against count-1.
//  stall is honoured only on ISSUE entry; it is ignored once start_mat_mul=1.
//  done_mat_mul outside ISSUE/RELEASE is ignored.
//  Reset mid-run aborts immediately; start_mat_mul drops asynchronously.
// TESTING
//  T1: m=n=k=1, base_a=0x10 -> one start pulse, addr_a=0x10, accumulate=0, last_k=1, done pulse, err=0.
//  T2: m=2,n=2,k=2, all steps=0x20 -> 8 tiles in (i,j,k) order; tile (1,1,1) has a=0x40, b=0x40, c=0x40; accumulate toggles 0,1.
//  T3: k_tiles=0 -> no start_mat_mul, err=1, done pulse 2 cycles after cfg_start.
//  T4: hold done_mat_mul=0 -> start drops after 255 cycles, err=1, done pulse, busy=0.
//  T5: stall=1 for 10 cycles at second tile -> start stays low 10 cycles, then resumes; result order unchanged.
//  T6: reset low during tile 3 of 8 -> all outputs 0 at once; a new cfg_start after release runs cleanly from tile 0.

Source files
------------

// File: rtl/matmul_tile_scheduler_if.sv
// Scheduler-to-datapath bundle: tile addresses, strides, masks, start/done
// handshake and the downstream C-writer stall.
interface matmul_tile_scheduler_if #(
    parameter int AWIDTH     = 11,
    parameter int SWIDTH     = 8,
    parameter int MASK_WIDTH = 4
);
    logic                  start_mat_mul;
    logic                  done_mat_mul;
    logic                  stall;
    logic [AWIDTH-1:0]     address_mat_a;
    logic [AWIDTH-1:0]     address_mat_b;
    logic [AWIDTH-1:0]     address_mat_c;
    logic [SWIDTH-1:0]     address_stride_a;
    logic [SWIDTH-1:0]     address_stride_b;
    logic [SWIDTH-1:0]     address_stride_c;
    logic [MASK_WIDTH-1:0] validity_mask_a_rows;
    logic [MASK_WIDTH-1:0] validity_mask_a_cols_b_rows;
    logic [MASK_WIDTH-1:0] validity_mask_b_cols;
    logic                  accumulate;
    logic                  last_k;

    modport master (
        output start_mat_mul, address_mat_a, address_mat_b, address_mat_c,
               address_stride_a, address_stride_b, address_stride_c,
               validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols,
               accumulate, last_k,
        input  done_mat_mul, stall
    );

    modport slave (
        input  start_mat_mul, address_mat_a, address_mat_b, address_mat_c,
               address_stride_a, address_stride_b, address_stride_c,
               validity_mask_a_rows, validity_mask_a_cols_b_rows, validity_mask_b_cols,
               accumulate, last_k,
        output done_mat_mul, stall
    );
endinterface

// File: rtl/matmul_tile_scheduler.sv
// Walks the (i,j,k) tile space of C = A*B, handing one 8x8 tile at a time to
// the systolic datapath and flagging when C writeback must accumulate.
module matmul_tile_scheduler #(
    parameter int AWIDTH     = 11,
    parameter int SWIDTH     = 8,
    parameter int MASK_WIDTH = 4,
    parameter int TWIDTH     = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_start,
    input  logic [AWIDTH-1:0]  cfg_base_a,
    input  logic [AWIDTH-1:0]  cfg_base_b,
    input  logic [AWIDTH-1:0]  cfg_base_c,
    input  logic [SWIDTH-1:0]  cfg_stride_a,
    input  logic [SWIDTH-1:0]  cfg_stride_b,
    input  logic [SWIDTH-1:0]  cfg_stride_c,
    input  logic [AWIDTH-1:0]  cfg_a_row_step,
    input  logic [AWIDTH-1:0]  cfg_a_col_step,
    input  logic [AWIDTH-1:0]  cfg_b_row_step,
    input  logic [AWIDTH-1:0]  cfg_b_col_step,
    input  logic [AWIDTH-1:0]  cfg_c_row_step,
    input  logic [AWIDTH-1:0]  cfg_c_col_step,
    input  logic [TWIDTH-1:0]  cfg_m_tiles,
    input  logic [TWIDTH-1:0]  cfg_n_tiles,
    input  logic [TWIDTH-1:0]  cfg_k_tiles,
    output logic               busy,
    output logic               done,
    output logic               err,
    matmul_tile_scheduler_if.master dp
);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CHECK   = 3'd1,
        S_ISSUE   = 3'd2,
        S_RELEASE = 3'd3,
        S_ADVANCE = 3'd4,
        S_FIN     = 3'd5
    } state_t;

    state_t              state_r, state_nxt_s;
    logic                start_r, start_nxt_s;
    logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
    logic [TWIDTH-1:0]   i_r, j_r, k_r, i_nxt_s, j_nxt_s, k_nxt_s;
    logic                err_set_s;
    logic                busy_r, done_r, err_r, acc_r, last_k_r;
    logic [MASK_WIDTH-1:0] mask_r;

    logic [AWIDTH-1:0]   base_a_r, base_b_r, base_c_r;
    logic [AWIDTH-1:0]   a_row_r, a_col_r, b_row_r, b_col_r, c_row_r, c_col_r;
    logic [TWIDTH-1:0]   m_r, n_r, kt_r;
    logic [SWIDTH-1:0]   stride_a_r, stride_b_r, stride_c_r;
    logic [AWIDTH-1:0]   addr_a_r, addr_b_r, addr_c_r;

    logic                accept_s;
    logic                load_tile_s;

    // Tile base address: base + p*step_p + q*step_q, wrapping modulo 2^AWIDTH.
    function automatic logic [AWIDTH-1:0] tile_addr(
        input logic [AWIDTH-1:0] base,
        input logic [TWIDTH-1:0] p,
        input logic [AWIDTH-1:0] step_p,
        input logic [TWIDTH-1:0] q,
        input logic [AWIDTH-1:0] step_q
    );
        logic [AWIDTH-1:0] sum;
        sum = base + (AWIDTH'(p) * step_p) + (AWIDTH'(q) * step_q);
        return sum;
    endfunction

    assign accept_s    = (state_r == S_IDLE) && cfg_start;
    assign load_tile_s = (state_nxt_s == S_ISSUE) && (state_r != S_ISSUE);

    // Next-state, start handshake, timeout and tile-counter sequencing.
    always_comb begin
        state_nxt_s = state_r;
        start_nxt_s = start_r;
        tmr_nxt_s   = tmr_r;
        i_nxt_s     = i_r;
        j_nxt_s     = j_r;
        k_nxt_s     = k_r;
        err_set_s   = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (cfg_start) begin
                    state_nxt_s = S_CHECK;
                    i_nxt_s     = {TWIDTH{1'b0}};
                    j_nxt_s     = {TWIDTH{1'b0}};
                    k_nxt_s     = {TWIDTH{1'b0}};
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if ((m_r == {TWIDTH{1'b0}}) || (n_r == {TWIDTH{1'b0}}) || (kt_r == {TWIDTH{1'b0}})) begin
                    state_nxt_s = S_FIN;
                    err_set_s   = 1'b1;
                end else begin
                    state_nxt_s = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Stall only gates the rising edge of start; once raised it is ignored.
                if (!start_r) begin
                    if (!dp.stall) begin
                        start_nxt_s = 1'b1;
                        tmr_nxt_s   = {TMR_W{1'b0}};
                    end else begin
                        start_nxt_s = 1'b0;
                    end
                end else if (dp.done_mat_mul) begin
                    start_nxt_s = 1'b0;
                    state_nxt_s = S_RELEASE;
                end else if (tmr_r == TMR_W'(TIMEOUT - 1)) begin
                    start_nxt_s = 1'b0;
                    err_set_s   = 1'b1;
                    state_nxt_s = S_FIN;
                end else begin
                    tmr_nxt_s = tmr_r + TMR_W'(1);
                end
            end
            S_RELEASE: begin
                if (!dp.done_mat_mul) begin
                    state_nxt_s = S_ADVANCE;
                end else begin
                    state_nxt_s = S_RELEASE;
                end
            end
            S_ADVANCE: begin
                state_nxt_s = S_ISSUE;
                if (k_r == (kt_r - TWIDTH'(1))) begin
                    k_nxt_s = {TWIDTH{1'b0}};
                    if (j_r == (n_r - TWIDTH'(1))) begin
                        j_nxt_s = {TWIDTH{1'b0}};
                        if (i_r == (m_r - TWIDTH'(1))) begin
                            i_nxt_s     = {TWIDTH{1'b0}};
                            state_nxt_s = S_FIN;
                        end else begin
                            i_nxt_s = i_r + TWIDTH'(1);
                        end
                    end else begin
                        j_nxt_s = j_r + TWIDTH'(1);
                    end
                end else begin
                    k_nxt_s = k_r + TWIDTH'(1);
                end
            end
            S_FIN: begin
                state_nxt_s = S_IDLE;
            end
            default: begin
                state_nxt_s = S_IDLE;
                start_nxt_s = 1'b0;
            end
        endcase
    end

    // Control state, counters and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= S_IDLE;
            start_r  <= 1'b0;
            tmr_r    <= {TMR_W{1'b0}};
            i_r      <= {TWIDTH{1'b0}};
            j_r      <= {TWIDTH{1'b0}};
            k_r      <= {TWIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            err_r    <= 1'b0;
            mask_r   <= {MASK_WIDTH{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            start_r  <= start_nxt_s;
            tmr_r    <= tmr_nxt_s;
            i_r      <= i_nxt_s;
            j_r      <= j_nxt_s;
            k_r      <= k_nxt_s;
            busy_r   <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_FIN);
            done_r   <= (state_nxt_s == S_FIN);
            mask_r   <= ((state_nxt_s != S_IDLE) && (state_nxt_s != S_FIN)) ?
                        {MASK_WIDTH{1'b1}} : {MASK_WIDTH{1'b0}};
            if (accept_s) begin
                err_r <= 1'b0;
            end else if (err_set_s) begin
                err_r <= 1'b1;
            end else begin
                err_r <= err_r;
            end
        end
    end

    // Configuration snapshot taken only when a run is accepted from idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_a_r <= {AWIDTH{1'b0}};  base_b_r <= {AWIDTH{1'b0}};  base_c_r <= {AWIDTH{1'b0}};
            a_row_r  <= {AWIDTH{1'b0}};  a_col_r  <= {AWIDTH{1'b0}};
            b_row_r  <= {AWIDTH{1'b0}};  b_col_r  <= {AWIDTH{1'b0}};
            c_row_r  <= {AWIDTH{1'b0}};  c_col_r  <= {AWIDTH{1'b0}};
            m_r      <= {TWIDTH{1'b0}};  n_r      <= {TWIDTH{1'b0}};  kt_r <= {TWIDTH{1'b0}};
            stride_a_r <= {SWIDTH{1'b0}}; stride_b_r <= {SWIDTH{1'b0}}; stride_c_r <= {SWIDTH{1'b0}};
        end else if (accept_s) begin
            base_a_r <= cfg_base_a;      base_b_r <= cfg_base_b;      base_c_r <= cfg_base_c;
            a_row_r  <= cfg_a_row_step;  a_col_r  <= cfg_a_col_step;
            b_row_r  <= cfg_b_row_step;  b_col_r  <= cfg_b_col_step;
            c_row_r  <= cfg_c_row_step;  c_col_r  <= cfg_c_col_step;
            m_r      <= cfg_m_tiles;     n_r      <= cfg_n_tiles;     kt_r <= cfg_k_tiles;
            stride_a_r <= cfg_stride_a;  stride_b_r <= cfg_stride_b;  stride_c_r <= cfg_stride_c;
        end else begin
            base_a_r <= base_a_r;
        end
    end

    // Tile addresses and k flags are loaded on ISSUE entry and held for the whole tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_a_r <= {AWIDTH{1'b0}};
            addr_b_r <= {AWIDTH{1'b0}};
            addr_c_r <= {AWIDTH{1'b0}};
            acc_r    <= 1'b0;
            last_k_r <= 1'b0;
        end else if (load_tile_s) begin
            addr_a_r <= tile_addr(base_a_r, i_nxt_s, a_row_r, k_nxt_s, a_col_r);
            addr_b_r <= tile_addr(base_b_r, k_nxt_s, b_row_r, j_nxt_s, b_col_r);
            addr_c_r <= tile_addr(base_c_r, i_nxt_s, c_row_r, j_nxt_s, c_col_r);
            acc_r    <= (k_nxt_s != {TWIDTH{1'b0}});
            last_k_r <= (k_nxt_s == (kt_r - TWIDTH'(1)));
        end else begin
            addr_a_r <= addr_a_r;
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign err  = err_r;

    assign dp.start_mat_mul               = start_r;
    assign dp.address_mat_a               = addr_a_r;
    assign dp.address_mat_b               = addr_b_r;
    assign dp.address_mat_c               = addr_c_r;
    assign dp.address_stride_a            = stride_a_r;
    assign dp.address_stride_b            = stride_b_r;
    assign dp.address_stride_c            = stride_c_r;
    assign dp.validity_mask_a_rows        = mask_r;
    assign dp.validity_mask_a_cols_b_rows = mask_r;
    assign dp.validity_mask_b_cols        = mask_r;
    assign dp.accumulate                  = acc_r;
    assign dp.last_k                      = last_k_r;
endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed + randomized bench for matmul_tile_scheduler; expected tile order,
// addresses and handshake timing come from a nested-loop reference model.
module tb_matmul_tile_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cfg_start = 1'b0;
    logic [10:0] cfg_base_a = '0, cfg_base_b = '0, cfg_base_c = '0;
    logic [7:0]  cfg_stride_a = '0, cfg_stride_b = '0, cfg_stride_c = '0;
    logic [10:0] cfg_a_row_step = '0, cfg_a_col_step = '0, cfg_b_row_step = '0;
    logic [10:0] cfg_b_col_step = '0, cfg_c_row_step = '0, cfg_c_col_step = '0;
    logic [3:0]  cfg_m_tiles = '0, cfg_n_tiles = '0, cfg_k_tiles = '0;
    logic        busy, done, err;
    int          checks = 0;
    int          errors = 0;

    matmul_tile_scheduler_if #(.AWIDTH(11), .SWIDTH(8), .MASK_WIDTH(4)) dp_if ();

    matmul_tile_scheduler dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start),
        .cfg_base_a(cfg_base_a), .cfg_base_b(cfg_base_b), .cfg_base_c(cfg_base_c),
        .cfg_stride_a(cfg_stride_a), .cfg_stride_b(cfg_stride_b), .cfg_stride_c(cfg_stride_c),
        .cfg_a_row_step(cfg_a_row_step), .cfg_a_col_step(cfg_a_col_step),
        .cfg_b_row_step(cfg_b_row_step), .cfg_b_col_step(cfg_b_col_step),
        .cfg_c_row_step(cfg_c_row_step), .cfg_c_col_step(cfg_c_col_step),
        .cfg_m_tiles(cfg_m_tiles), .cfg_n_tiles(cfg_n_tiles), .cfg_k_tiles(cfg_k_tiles),
        .busy(busy), .done(done), .err(err), .dp(dp_if.master)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_addr(input int base, input int p, input int sp, input int q, input int sq);
        return 32'((base + p * sp + q * sq) % 2048);
    endfunction

    task automatic set_cfg(input int m, input int n, input int k);
        cfg_m_tiles = 4'(m); cfg_n_tiles = 4'(n); cfg_k_tiles = 4'(k);
    endtask

    task automatic randomize_cfg();
        cfg_base_a = 11'($urandom); cfg_base_b = 11'($urandom); cfg_base_c = 11'($urandom);
        cfg_a_row_step = 11'($urandom); cfg_a_col_step = 11'($urandom);
        cfg_b_row_step = 11'($urandom); cfg_b_col_step = 11'($urandom);
        cfg_c_row_step = 11'($urandom); cfg_c_col_step = 11'($urandom);
        cfg_stride_a = 8'($urandom); cfg_stride_b = 8'($urandom); cfg_stride_c = 8'($urandom);
    endtask

    // One complete run: pulse cfg_start, play the datapath, check every tile.
    task automatic run_job(input int stall_tile, input int abort_tile, input bit hang);
        int m, n, kk, cnt, t, lat, exp_wait;
        bit seen;
        m = int'(cfg_m_tiles); n = int'(cfg_n_tiles); kk = int'(cfg_k_tiles);
        step();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        check("strides", {dp_if.address_stride_a, dp_if.address_stride_b, dp_if.address_stride_c},
              {cfg_stride_a, cfg_stride_b, cfg_stride_c});
        check("masks_busy", {dp_if.validity_mask_a_rows, dp_if.validity_mask_a_cols_b_rows,
              dp_if.validity_mask_b_cols}, 32'hFFF);
        if (m == 0 || n == 0 || kk == 0) begin
            cnt = 0; seen = 1'b0;
            while (!done && cnt < 20) begin
                step(); cnt++;
                if (dp_if.start_mat_mul) seen = 1'b1;
            end
            check("zero_done_lat", cnt, 1);
            check("zero_err", err, 1);
            check("zero_no_start", seen, 0);
            check("zero_busy", busy, 0);
            step();
            check("zero_done_pulse", done, 0);
            return;
        end
        t = 0;
        for (int i = 0; i < m; i++) begin
            for (int j = 0; j < n; j++) begin
                for (int k = 0; k < kk; k++) begin
                    cnt = 0;
                    if (t == stall_tile && t > 0) begin
                        seen = 1'b0;
                        for (int s = 0; s < 10; s++) begin
                            step();
                            if (dp_if.start_mat_mul) seen = 1'b1;
                        end
                        check("stall_holds_start", seen, 0);
                        dp_if.stall = 1'b0;
                    end
                    while (!dp_if.start_mat_mul && cnt < 40) begin
                        step(); cnt++;
                    end
                    exp_wait = (t == 0) ? 2 : ((t == stall_tile) ? 1 : 3);
                    check("issue_gap", cnt, exp_wait);
                    check("addr_a", dp_if.address_mat_a, ref_addr(cfg_base_a, i, cfg_a_row_step, k, cfg_a_col_step));
                    check("addr_b", dp_if.address_mat_b, ref_addr(cfg_base_b, k, cfg_b_row_step, j, cfg_b_col_step));
                    check("addr_c", dp_if.address_mat_c, ref_addr(cfg_base_c, i, cfg_c_row_step, j, cfg_c_col_step));
                    check("accumulate", dp_if.accumulate, (k != 0) ? 1 : 0);
                    check("last_k", dp_if.last_k, (k == kk - 1) ? 1 : 0);
                    check("busy_in_tile", busy, 1);
                    if (t == abort_tile) begin
                        reset = 1'b0;
                        #1;
                        check("abort_outputs", {dp_if.start_mat_mul, busy, done, err, dp_if.accumulate,
                              dp_if.validity_mask_a_rows, dp_if.address_mat_a}, 0);
                        step(); step();
                        reset = 1'b1;
                        step();
                        return;
                    end
                    if (hang) begin
                        cnt = 0;
                        while (dp_if.start_mat_mul && cnt < 400) begin
                            step(); cnt++;
                        end
                        check("timeout_len", cnt, 255);
                        check("timeout_done", done, 1);
                        check("timeout_err", err, 1);
                        check("timeout_busy", busy, 0);
                        step();
                        check("timeout_done_pulse", done, 0);
                        return;
                    end
                    lat = int'($urandom_range(0, 6));
                    repeat (lat) step();
                    check("start_held", dp_if.start_mat_mul, 1);
                    if (t + 1 == stall_tile) dp_if.stall = 1'b1;
                    dp_if.done_mat_mul = 1'b1;
                    step();
                    check("start_drops", dp_if.start_mat_mul, 0);
                    dp_if.done_mat_mul = 1'b0;
                    t++;
                end
            end
        end
        cnt = 0;
        while (!done && cnt < 20) begin
            step(); cnt++;
        end
        check("fin_lat", cnt, 2);
        check("fin_busy", busy, 0);
        check("fin_err", err, 0);
        step();
        check("done_pulse", done, 0);
    endtask

    initial begin
        dp_if.done_mat_mul = 1'b0;
        dp_if.stall = 1'b0;
        repeat (3) step();
        check("reset_outputs", {dp_if.start_mat_mul, busy, done, err, dp_if.accumulate, dp_if.last_k,
              dp_if.validity_mask_b_cols, dp_if.address_mat_a}, 0);
        check("reset_addr_bc", {dp_if.address_mat_b, dp_if.address_mat_c}, 0);
        reset = 1'b1;
        step();

        // T1: single tile
        cfg_base_a = 11'h010; cfg_base_b = 11'h100; cfg_base_c = 11'h200;
        cfg_stride_a = 8'h08; cfg_stride_b = 8'h10; cfg_stride_c = 8'h20;
        set_cfg(1, 1, 1);
        run_job(-1, -1, 1'b0);

        // T2: 2x2x2 with all steps 0x20
        cfg_base_a = 11'h000; cfg_base_b = 11'h000; cfg_base_c = 11'h000;
        cfg_a_row_step = 11'h020; cfg_a_col_step = 11'h020; cfg_b_row_step = 11'h020;
        cfg_b_col_step = 11'h020; cfg_c_row_step = 11'h020; cfg_c_col_step = 11'h020;
        set_cfg(2, 2, 2);
        run_job(-1, -1, 1'b0);

        // T3: zero k tiles
        set_cfg(2, 2, 0);
        run_job(-1, -1, 1'b0);

        // T4: datapath never answers
        set_cfg(1, 1, 1);
        run_job(-1, -1, 1'b1);

        // T5: stall on second tile
        set_cfg(2, 2, 2);
        run_job(1, -1, 1'b0);

        // T6: reset during tile 3, then a clean rerun
        run_job(-1, 2, 1'b0);
        run_job(-1, -1, 1'b0);

        // Long k with wrapping addresses
        cfg_base_a = 11'h7F8; cfg_a_col_step = 11'h7F0; cfg_b_row_step = 11'h111;
        set_cfg(1, 1, 15);
        run_job(-1, -1, 1'b0);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            randomize_cfg();
            set_cfg(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
            run_job((r % 2 == 1) ? int'($urandom_range(1, 2)) : -1, -1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
